seg7_scan_ctrl: RTL

Time-multiplexed 4-digit seven-segment scan controller that sits around the 4-bit 4:1 digit multiplexer. It drives the mux `SEL` input upstream, consumes the selected nibble `Y_IN` downstream, and decodes it to hex seven-segment patterns. It also drives the common-anode enables with a guard interval, per-digit decimal points, and optional leading-zero blanking. All outputs are registered and glitch-free.

---
 rtl/seg7_scan_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode seven-segment scanner: steps the external digit mux,
// samples the returned nibble once per slot and drives registered SEG/AN/DP with a guard gap.
module seg7_scan_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int GUARD    = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [3:0] Y_IN,
  input  logic       LZB,
  input  logic [3:0] DP_IN,
  output logic [1:0] SEL,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       FRAME
);

  localparam int            CW         = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(GUARD - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  phase_t        r_phase;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame;
  logic          r_zero3;
  logic          r_zero2;

  logic          w_wrap;
  logic          w_sample;
  logic          w_y_zero;
  logic          w_blank;
  logic [3:0]    w_an_drive;
  logic [6:0]    w_glyph;

  assign w_wrap     = (r_cnt == CNT_LAST);
  assign w_sample   = (r_phase == PH_GUARD) && (r_cnt == CNT_SAMPLE);
  assign w_y_zero   = (Y_IN == 4'd0);
  assign w_an_drive = ~(4'b0001 << r_sel);

  always_comb begin
    w_glyph = 7'h7F;
    unique case (Y_IN)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

  // The scan visits digits upward, so the zero run from the top is kept as the most
  // recent zero flags of digits 3 and 2 rather than a single chained bit.
  always_comb begin
    w_blank = 1'b0;
    unique case (r_sel)
      2'd3:    w_blank = w_y_zero;
      2'd2:    w_blank = r_zero3 & w_y_zero;
      2'd1:    w_blank = r_zero3 & r_zero2 & w_y_zero;
      default: w_blank = 1'b0;
    endcase
    w_blank = w_blank & LZB;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_phase <= PH_GUARD;
      r_cnt   <= '0;
      r_sel   <= 2'd0;
      r_an    <= 4'hF;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      r_frame <= 1'b0;
      r_zero3 <= 1'b0;
      r_zero2 <= 1'b0;
    end else if (!EN) begin
      r_phase <= PH_GUARD;
      r_cnt   <= '0;
      r_an    <= 4'hF;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (w_wrap) begin
        r_cnt   <= '0;
        r_sel   <= r_sel + 2'd1;
        r_frame <= (r_sel == 2'd3);
        r_phase <= PH_GUARD;
        r_an    <= 4'hF;
        r_seg   <= 7'h7F;
        r_dp    <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
        // Sample one cycle after SEL has settled; the result is held for the rest of the slot.
        if (w_sample) begin
          r_phase <= PH_DRIVE;
          r_an    <= w_an_drive;
          r_seg   <= w_blank ? 7'h7F : w_glyph;
          r_dp    <= ~DP_IN[r_sel];
          if (r_sel == 2'd3) r_zero3 <= w_y_zero;
          if (r_sel == 2'd2) r_zero2 <= w_y_zero;
        end
      end
    end
  end

  assign SEL   = r_sel;
  assign AN    = r_an;
  assign SEG   = r_seg;
  assign DP    = r_dp;
  assign FRAME = r_frame;

endmodule
